// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide unit for the execute stage.
//
// Decodes M-extension ops straight from the id_ex register outputs and runs
// either a 32-step shift-add multiply or a 32-step restoring divide. While an
// op is in flight, stall_o holds pc/if_id/id_ex. The result is written back
// through a one-cycle strobe in DONE.
//
// Configuration macro: MDU_FAST_MUL_EN. When it is defined, multiplies finish
// in a single cycle (IDLE -> DONE). Division is the same in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active LOW
//   inst_i     instruction (opcode/funct3/funct7 are decoded here)
//   op1_i      rs1 value (multiplicand / dividend)
//   op2_i      rs2 value (multiplier / divisor)
//   rd_addr_i  destination register
//   reg_wen_i  write enable from decode
//   flush_i    pipeline flush; aborts an op that is still iterating
//   rd_data_o  result, non-zero only in DONE
//   rd_addr_o  destination register latched at start
//   reg_wen_o  one-cycle write strobe in DONE
//   stall_o    pipeline hold while an M-op is pending or in flight
module ex_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    input  logic        flush_i,
    output logic [31:0] rd_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_wen_o,
    output logic        stall_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [2:0]  f3_q;
    logic [4:0]  rd_addr_q;
    logic        wen_q;
    logic        neg_q;      // sign of the product or quotient
    logic        neg_r;      // sign of the remainder
    logic [63:0] acc;        // product accumulator; the remainder lives in [31:0]
    logic [63:0] opa;        // shifted multiplicand, or the divisor in [31:0]
    logic [31:0] opb;        // multiplier; for divide, the dividend shifting into the quotient

    // decode
    logic [2:0]  f3;
    logic        is_m, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [31:0] mag1, mag2;

    assign f3   = inst_i[14:12];
    assign is_m = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
    // Signed operands: MUL/MULH/MULHSU rs1, MUL/MULH rs2, DIV/REM both.
    assign sgn1 = f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    assign sgn2 = f3[2] ? ~f3[0] : ~f3[1];
    assign neg1 = sgn1 & op1_i[31];
    assign neg2 = sgn2 & op2_i[31];
    assign mag1 = neg1 ? (~op1_i + 32'd1) : op1_i;
    assign mag2 = neg2 ? (~op2_i + 32'd1) : op2_i;
    assign div_zero = (op2_i == 32'd0);
    assign div_ovf  = sgn1 && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);

    logic unused_inst;
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

`ifdef MDU_FAST_MUL_EN
    // The 64-bit product of the sign/zero-extended operands, taken mod 2^64,
    // equals the low 64 bits of the 33x33 signed product.
    logic [63:0] ext1, ext2, fast_prod;
    assign ext1      = {{32{neg1}}, op1_i};
    assign ext2      = {{32{neg2}}, op2_i};
    assign fast_prod = ext1 * ext2;
`endif

    // one restoring-divide step
    logic [32:0] rem_sh;
    logic [33:0] trial;
    assign rem_sh = {acc[31:0], opb[31]};
    assign trial  = {1'b0, rem_sh} - {2'b00, opa[31:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            rd_addr_q <= '0;
            wen_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
        end else begin
            case (state)
                S_IDLE: if (is_m && !flush_i) begin
                    f3_q      <= f3;
                    rd_addr_q <= rd_addr_i;
                    wen_q     <= reg_wen_i;
                    cnt       <= '0;
                    neg_r     <= 1'b0;
                    if (!f3[2]) begin
`ifdef MDU_FAST_MUL_EN
                        acc   <= fast_prod;
                        neg_q <= 1'b0;
                        state <= S_DONE;
`else
                        acc   <= '0;
                        opa   <= {32'd0, mag1};
                        opb   <= mag2;
                        neg_q <= neg1 ^ neg2;
                        state <= S_MUL;
`endif
                    end else if (div_zero) begin
                        // Load the registers so the normal result mux yields
                        // quotient all-ones and remainder op1.
                        opb   <= 32'hFFFF_FFFF;
                        acc   <= {32'd0, op1_i};
                        neg_q <= 1'b0;
                        state <= S_DONE;
                    end else if (div_ovf) begin
                        opb   <= 32'h8000_0000;
                        acc   <= '0;
                        neg_q <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        acc   <= '0;
                        opa   <= {32'd0, mag2};
                        opb   <= mag1;
                        neg_q <= neg1 ^ neg2;
                        neg_r <= neg1;
                        state <= S_DIV;
                    end
                end
                S_MUL: begin
                    acc <= acc + (opb[0] ? opa : 64'd0);
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 5'd1;
                    if (flush_i)              state <= S_IDLE;
                    else if (cnt == 5'd31)    state <= S_DONE;
                end
                S_DIV: begin
                    if (trial[33]) begin
                        acc[31:0] <= rem_sh[31:0];
                        opb       <= {opb[30:0], 1'b0};
                    end else begin
                        acc[31:0] <= trial[31:0];
                        opb       <= {opb[30:0], 1'b1};
                    end
                    cnt <= cnt + 5'd1;
                    if (flush_i)              state <= S_IDLE;
                    else if (cnt == 5'd31)    state <= S_DONE;
                end
                default: state <= S_IDLE;     // DONE: write retires, a flush cannot stop it
            endcase
        end
    end

    // result formatting
    logic [63:0] prod;
    logic [31:0] quo, rem, res;
    assign prod = neg_q ? (~acc + 64'd1) : acc;
    assign quo  = neg_q ? (~opb + 32'd1) : opb;
    assign rem  = neg_r ? (~acc[31:0] + 32'd1) : acc[31:0];

    always_comb begin
        res = 32'd0;
        case (f3_q)
            3'b000:                 res = prod[31:0];
            3'b001, 3'b010, 3'b011: res = prod[63:32];
            3'b100, 3'b101:         res = quo;
            default:                res = rem;
        endcase
    end

    assign rd_data_o = (state == S_DONE) ? res : 32'd0;
    assign reg_wen_o = (state == S_DONE) & wen_q;
    assign rd_addr_o = rd_addr_q;
    // Combinational so the hold is already in effect in the start cycle. A flush
    // releases it at once because the in-flight op is being discarded.
    assign stall_o = rst & ~flush_i &
                     ((is_m & (state != S_DONE)) | (state == S_MUL) | (state == S_DIV));

endmodule
